// File: rtl/display_pkg.sv
// Shared display-subsystem constants and the fill FSM state type.
// Sized copies of the screen limits let comparisons stay width-exact.
package display_pkg;

  localparam int H_RES     = 320;
  localparam int V_RES     = 240;
  localparam int FB_ADDR_W = 16;
  localparam int COLOR_W   = 12;

  localparam logic [9:0]  H_RES_X   = 10'(H_RES);
  localparam logic [8:0]  V_RES_Y   = 9'(V_RES);
  localparam logic [16:0] ROW_PITCH = 17'(H_RES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle walker: holds the current column/row and row base address, clipped to the screen.
// Address and last-pixel flag are combinational from the registered position.
module fb_rect_walker
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [8:0]  i_x0,
  input  logic [7:0]  i_y0,
  input  logic [8:0]  i_w,
  input  logic [7:0]  i_h,
  output logic        o_empty,
  output logic [16:0] o_addr,
  output logic        o_last
);

  logic [9:0]  w_x_sum;
  logic [8:0]  w_y_sum;
  logic [9:0]  w_x_end;
  logic [8:0]  w_y_end;
  logic        w_row_end;

  logic [8:0]  r_x0;
  logic [8:0]  r_cx;
  logic [7:0]  r_cy;
  logic [9:0]  r_x_end;
  logic [8:0]  r_y_end;
  logic [16:0] r_row_base;

  // Sums are one bit wider than the operands so the clip never sees a wrapped value.
  assign w_x_sum = {1'b0, i_x0} + {1'b0, i_w};
  assign w_y_sum = {1'b0, i_y0} + {1'b0, i_h};
  assign w_x_end = (w_x_sum > H_RES_X) ? H_RES_X : w_x_sum;
  assign w_y_end = (w_y_sum > V_RES_Y) ? V_RES_Y : w_y_sum;

  assign o_empty = (i_w == 9'd0) || (i_h == 8'd0) ||
                   ({1'b0, i_x0} >= H_RES_X) || ({1'b0, i_y0} >= V_RES_Y);

  assign w_row_end = ({1'b0, r_cx} == (r_x_end - 10'd1));
  assign o_last    = w_row_end && ({1'b0, r_cy} == (r_y_end - 9'd1));
  assign o_addr    = r_row_base + {8'b0, r_cx};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_x0       <= i_x0;
      r_cx       <= i_x0;
      r_cy       <= i_y0;
      r_x_end    <= w_x_end;
      r_y_end    <= w_y_end;
      r_row_base <= 17'(i_y0) * ROW_PITCH;
    end else if (i_advance) begin
      if (w_row_end) begin
        r_cx       <= r_x0;
        r_cy       <= r_cy + 8'd1;
        r_row_base <= r_row_base + ROW_PITCH;
      end else begin
        r_cx <= r_cx + 9'd1;
      end
    end
  end

endmodule

// File: rtl/fb_fill_arbiter.sv
// Shares the frame-buffer write port between CPU writes (always win) and the rectangle-fill engine.
// All outputs registered: a write accepted in cycle N is presented on fb_* in cycle N+1.
module fb_fill_arbiter
  import display_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_write,
  input  logic [FB_ADDR_W-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic                 fill_start,
  input  logic [8:0]           fill_x0,
  input  logic [7:0]           fill_y0,
  input  logic [8:0]           fill_w,
  input  logic [7:0]           fill_h,
  input  logic [COLOR_W-1:0]   fill_color,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic                 fb_write,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [31:0]          fb_wdata
);

  fill_state_e r_state;
  fill_state_e w_next_state;

  logic [COLOR_W-1:0]   r_color;
  logic                 r_write;
  logic [FB_ADDR_W-1:0] r_addr;
  logic [31:0]          r_wdata;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_load;
  logic                 w_advance;
  logic                 w_empty;
  logic                 w_last;
  logic [16:0]          w_walk_addr;
  logic                 w_nxt_write;
  logic [FB_ADDR_W-1:0] w_nxt_addr;
  logic [31:0]          w_nxt_wdata;
  logic                 w_nxt_busy;
  logic                 w_nxt_done;

  assign w_load    = (r_state == IDLE) && fill_start;
  // The walker only moves on cycles the CPU leaves the port idle.
  assign w_advance = (r_state == FILL) && !cpu_write;

  fb_rect_walker u_walker (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_x0      (fill_x0),
    .i_y0      (fill_y0),
    .i_w       (fill_w),
    .i_h       (fill_h),
    .o_empty   (w_empty),
    .o_addr    (w_walk_addr),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (fill_start) w_next_state = w_empty ? DONE : FILL;
      FILL:    if (w_advance && w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_nxt_write = 1'b0;
    w_nxt_addr  = r_addr;
    w_nxt_wdata = r_wdata;
    if (cpu_write) begin
      w_nxt_write = 1'b1;
      w_nxt_addr  = cpu_addr;
      w_nxt_wdata = cpu_wdata;
    end else if ((r_state == FILL) && !w_walk_addr[FB_ADDR_W]) begin
      w_nxt_write = 1'b1;
      w_nxt_addr  = w_walk_addr[FB_ADDR_W-1:0];
      w_nxt_wdata = {{(32-COLOR_W){1'b0}}, r_color};
    end
    w_nxt_busy = (w_next_state != IDLE);
    w_nxt_done = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_color <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_load) r_color <= fill_color;
      r_write <= w_nxt_write;
      r_addr  <= w_nxt_addr;
      r_wdata <= w_nxt_wdata;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  assign fb_write  = r_write;
  assign fb_addr   = r_addr;
  assign fb_wdata  = r_wdata;
  assign fill_busy = r_busy;
  assign fill_done = r_done;

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Bench for fb_fill_arbiter: directed cases plus random traffic against a pixel-queue reference model.
module tb_fb_fill_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_write;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        fill_start;
  logic [8:0]  fill_x0;
  logic [7:0]  fill_y0;
  logic [8:0]  fill_w;
  logic [7:0]  fill_h;
  logic [11:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        fb_write;
  logic [15:0] fb_addr;
  logic [31:0] fb_wdata;

  fb_fill_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .fill_start (fill_start),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fb_write   (fb_write),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a fill is the list of on-screen pixel addresses, consumed one per CPU-free cycle.
  int          q[$];
  bit          m_done_cyc;
  bit          e_write, e_busy, e_done;
  logic [15:0] e_addr;
  logic [31:0] e_data;
  logic [11:0] m_color;
  int          n_wr, n_busy, n_done;

  task automatic model_reset();
    q.delete();
    m_done_cyc = 1'b0;
    e_write = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_addr = '0; e_data = '0;
  endtask

  task automatic model_edge();
    bit nxt_done;
    int p, xe, ye;
    nxt_done = 1'b0;
    e_done   = m_done_cyc;
    e_write  = 1'b0;
    if (cpu_write) begin
      e_write = 1'b1; e_addr = cpu_addr; e_data = cpu_wdata;
    end
    if (q.size() > 0) begin
      if (!cpu_write) begin
        p = q.pop_front();
        if (p < 65536) begin
          e_write = 1'b1; e_addr = 16'(p); e_data = {20'b0, m_color};
        end
        if (q.size() == 0) nxt_done = 1'b1;
      end
    end else if (!m_done_cyc && fill_start) begin
      m_color = fill_color;
      xe = int'(fill_x0) + int'(fill_w); if (xe > 320) xe = 320;
      ye = int'(fill_y0) + int'(fill_h); if (ye > 240) ye = 240;
      for (int y = int'(fill_y0); y < ye; y++)
        for (int x = int'(fill_x0); x < xe; x++)
          q.push_back(y * 320 + x);
      if (q.size() == 0) nxt_done = 1'b1;
    end
    m_done_cyc = nxt_done;
    e_busy     = (q.size() > 0) || nxt_done;
  endtask

  task automatic compare();
    chk("fb_write", 32'(fb_write), 32'(e_write));
    chk("fill_busy", 32'(fill_busy), 32'(e_busy));
    chk("fill_done", 32'(fill_done), 32'(e_done));
    if (e_write) begin
      chk("fb_addr", 32'(fb_addr), 32'(e_addr));
      chk("fb_wdata", fb_wdata, e_data);
    end
    n_wr   += int'(fb_write);
    n_busy += int'(fill_busy);
    n_done += int'(fill_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic start_fill(input int x0, input int y0, input int w, input int h, input logic [11:0] c);
    fill_start = 1'b1;
    fill_x0 = 9'(x0); fill_y0 = 8'(y0); fill_w = 9'(w); fill_h = 8'(h); fill_color = c;
    cycle();
    fill_start = 1'b0;
  endtask

  task automatic clr_counts();
    n_wr = 0; n_busy = 0; n_done = 0;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare();
  endtask

  initial begin
    reset = 1'b1; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;
    clr_counts();
    #2;
    model_reset();
    compare();
    run(2);
    reset = 1'b0;

    // Basic 4x2 fill
    clr_counts();
    start_fill(10, 5, 4, 2, 12'hF00);
    run(12);
    chk("t1_writes", 32'(n_wr), 32'd8);
    chk("t1_busy_cycles", 32'(n_busy), 32'd9);
    chk("t1_done_pulses", 32'(n_done), 32'd1);

    // Horizontal clip at the right screen edge
    clr_counts();
    start_fill(318, 0, 5, 1, 12'h0A5);
    run(6);
    chk("clip_writes", 32'(n_wr), 32'd2);
    chk("clip_done", 32'(n_done), 32'd1);

    // Address 65536 suppressed
    clr_counts();
    start_fill(255, 204, 2, 1, 12'h123);
    run(6);
    chk("supp_writes", 32'(n_wr), 32'd1);
    chk("supp_done", 32'(n_done), 32'd1);

    // CPU preempts on the third fill cycle
    clr_counts();
    start_fill(10, 5, 4, 2, 12'hF00);
    run(2);
    cpu_write = 1'b1; cpu_addr = 16'h0007; cpu_wdata = 32'hABC;
    cycle();
    cpu_write = 1'b0;
    chk("pre_addr", 32'(fb_addr), 32'd7);
    chk("pre_data", fb_wdata, 32'hABC);
    run(10);
    chk("pre_writes", 32'(n_wr), 32'd9);
    chk("pre_done", 32'(n_done), 32'd1);

    // Empty rectangles
    clr_counts();
    start_fill(10, 5, 0, 2, 12'hFFF);
    cycle();
    chk("w0_done_at2", 32'(fill_done), 32'd1);
    run(3);
    start_fill(400, 5, 4, 2, 12'hFFF);
    cycle();
    chk("x400_done_at2", 32'(fill_done), 32'd1);
    run(3);
    chk("empty_writes", 32'(n_wr), 32'd0);

    // Start while busy is ignored
    clr_counts();
    start_fill(10, 5, 4, 2, 12'h0F0);
    run(3);
    start_fill(0, 0, 3, 3, 12'h00F);
    run(12);
    chk("busy_start_writes", 32'(n_wr), 32'd8);
    chk("busy_start_done", 32'(n_done), 32'd1);

    // Reset after three fill pixels
    clr_counts();
    start_fill(10, 5, 4, 2, 12'hF00);
    run(3);
    async_reset();
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_wdata", fb_wdata, 32'd0);
    run(2);
    reset = 1'b0;
    run(4);
    chk("rst_no_done", 32'(n_done), 32'd0);
    clr_counts();
    start_fill(318, 1, 3, 2, 12'h456);
    run(8);
    chk("post_rst_writes", 32'(n_wr), 32'd4);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cpu_write  = ($urandom_range(0, 3) == 0);
      cpu_addr   = 16'($urandom);
      cpu_wdata  = $urandom;
      fill_start = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: begin fill_x0 = 9'($urandom_range(0, 511)); fill_y0 = 8'($urandom_range(0, 255)); end
        1: begin fill_x0 = 9'($urandom_range(300, 330)); fill_y0 = 8'($urandom_range(230, 245)); end
        2: begin fill_x0 = 9'($urandom_range(250, 260)); fill_y0 = 8'($urandom_range(200, 210)); end
        default: begin fill_x0 = 9'($urandom_range(0, 20)); fill_y0 = 8'($urandom_range(0, 20)); end
      endcase
      fill_w     = 9'($urandom_range(0, 10));
      fill_h     = 8'($urandom_range(0, 4));
      fill_color = 12'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end
    cpu_write = 1'b0;
    fill_start = 1'b0;
    run(60);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
